// File: rtl/access_trace_buffer.sv
// Multi-channel memory access trace FIFO with drop/overwrite policy and
// saturating event counters.
module access_trace_buffer #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned CNT_W    = 16,
   localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned PTR_W   = $clog2(DEPTH),
   localparam int unsigned ENTRY_W = CH_W + 1 + ADDR_W
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       trace_en_i,
   input  logic                       overwrite_i,
   input  logic [CHANNELS-1:0]        ch_valid_i,
   input  logic [CHANNELS-1:0]        ch_write_i,
   input  logic [CHANNELS*ADDR_W-1:0] ch_addr_i,
   output logic                       rd_valid_o,
   input  logic                       rd_ready_i,
   output logic [ENTRY_W-1:0]         rd_data_o,
   output logic [PTR_W:0]             count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [CNT_W-1:0]           total_cnt_o,
   output logic [CNT_W-1:0]           drop_cnt_o
);

   localparam int unsigned NOFF_W = $clog2(CHANNELS + 1);
   localparam int unsigned SUM_W  = CNT_W + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]     count_q, count_d;
   logic [CNT_W-1:0]   total_q, total_d, drop_q, drop_d;

   logic [CHANNELS-1:0] offered;
   logic [NOFF_W-1:0]   n_off, n_drop;
   logic                win;
   logic [CH_W-1:0]     win_idx;
   logic [ADDR_W-1:0]   win_addr;
   logic                win_wr;
   logic                pop, full;
   logic                mem_we;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [NOFF_W-1:0] b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   assign full        = (count_q == (PTR_W+1)'(DEPTH));
   assign full_o      = full;
   assign empty_o     = (count_q == '0);
   assign rd_valid_o  = !empty_o;
   assign rd_data_o   = mem_q[head_q];
   assign count_o     = count_q;
   assign total_cnt_o = total_q;
   assign drop_cnt_o  = drop_q;

   // Offered accesses and lowest-index winner
   always_comb begin
      offered  = trace_en_i ? ch_valid_i : '0;
      n_off    = '0;
      win_idx  = '0;
      win_addr = '0;
      win_wr   = 1'b0;
      for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
         n_off = n_off + NOFF_W'(offered[k]);
         if (offered[k]) begin
            win_idx  = CH_W'(k);
            win_addr = ch_addr_i[k*ADDR_W +: ADDR_W];
            win_wr   = ch_write_i[k];
         end
      end
      win = |offered;
   end

   // Pointer, occupancy and counter next-state
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      mem_we  = 1'b0;
      n_drop  = '0;
      pop     = rd_valid_o && rd_ready_i;
      if (win) begin
         if (!full || pop) begin
            mem_we = 1'b1;
            tail_d = tail_q + PTR_W'(1);
            n_drop = n_off - NOFF_W'(1);
            if (!pop) count_d = count_q + (PTR_W+1)'(1);
         end else begin
            n_drop = n_off;
            if (overwrite_i) begin
               mem_we = 1'b1;
               tail_d = tail_q + PTR_W'(1);
               head_d = head_q + PTR_W'(1);
            end
         end
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
         if (!win) count_d = count_q - (PTR_W+1)'(1);
      end
      total_d = sat_add(total_q, n_off);
      drop_d  = sat_add(drop_q, n_drop);
      if (clear_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         total_d = '0;
         drop_d  = '0;
         mem_we  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         total_q <= '0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         total_q <= total_d;
         drop_q  <= drop_d;
      end
   end

   // Trace storage is intentionally not reset
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) mem_q[tail_q] <= {win_idx, win_wr, win_addr};
   end

endmodule

// File: tb/tb_access_trace_buffer.sv
// Directed bench for access_trace_buffer with a queue-based reference model
// compared every cycle, plus literal checks.
module tb_access_trace_buffer;
   localparam int unsigned AW = 32;
   localparam int unsigned NC = 2;
   localparam int unsigned DP = 16;
   localparam int unsigned CW = 16;
   localparam int unsigned EW = 1 + 1 + AW;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1, clear_i = 1'b0, trace_en_i = 1'b0, overwrite_i = 1'b0;
   logic [NC-1:0] ch_valid_i = '0, ch_write_i = '0;
   logic [NC*AW-1:0] ch_addr_i = '0;
   logic          rd_ready_i = 1'b0;
   logic          rd_valid_o, full_o, empty_o;
   logic [EW-1:0] rd_data_o;
   logic [4:0]    count_o;
   logic [CW-1:0] total_cnt_o, drop_cnt_o;

   int n_tests = 0, n_fail = 0;
   bit chk_en = 1'b0;

   access_trace_buffer #(.ADDR_W(AW), .CHANNELS(NC), .DEPTH(DP), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .trace_en_i(trace_en_i),
      .overwrite_i(overwrite_i), .ch_valid_i(ch_valid_i), .ch_write_i(ch_write_i),
      .ch_addr_i(ch_addr_i), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
      .rd_data_o(rd_data_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
      .total_cnt_o(total_cnt_o), .drop_cnt_o(drop_cnt_o));

   always #5 clk = ~clk;

   // Reference model: FIFO as a queue, counters as saturating integers
   logic [EW-1:0] mq[$];
   int m_total = 0, m_drop = 0;

   always @(posedge clk) begin
      int n;
      logic [EW-1:0] e;
      if (rst_i || clear_i) begin
         mq.delete();
         m_total = 0;
         m_drop  = 0;
      end else begin
         n = 0;
         e = '0;
         if (trace_en_i) begin
            for (int k = int'(NC) - 1; k >= 0; k--) begin
               if (ch_valid_i[k]) begin
                  n++;
                  e = {1'(k), ch_write_i[k], ch_addr_i[k*AW +: AW]};
               end
            end
         end
         if (mq.size() > 0 && rd_ready_i) void'(mq.pop_front());
         if (n > 0) begin
            if (mq.size() < DP) begin
               mq.push_back(e);
               m_drop += n - 1;
            end else begin
               m_drop += n;
               if (overwrite_i) begin
                  void'(mq.pop_front());
                  mq.push_back(e);
               end
            end
         end
         m_total += n;
         if (m_total > 65535) m_total = 65535;
         if (m_drop > 65535) m_drop = 65535;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_count", 64'(count_o), 64'(mq.size()));
         check("m_empty", 64'(empty_o), 64'(mq.size() == 0));
         check("m_full", 64'(full_o), 64'(mq.size() == DP));
         check("m_valid", 64'(rd_valid_o), 64'(mq.size() != 0));
         check("m_total", 64'(total_cnt_o), 64'(m_total));
         check("m_drop", 64'(drop_cnt_o), 64'(m_drop));
         if (mq.size() != 0) check("m_data", 64'(rd_data_o), 64'(mq[0]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   task automatic fill(input int n, input int ch, input int base);
      for (int i = 0; i < n; i++) begin
         ch_valid_i = '0;
         ch_valid_i[ch] = 1'b1;
         ch_addr_i[ch*AW +: AW] = 32'(base + i);
         tick();
      end
      ch_valid_i = '0;
   endtask

   task automatic drain_check(input int n, input int ch, input int base, input string name);
      for (int i = 0; i < n; i++) begin
         check(name, 64'(rd_data_o), 64'({1'(ch), 1'b0, 32'(base + i)}));
         rd_ready_i = 1'b1;
         tick();
      end
      rd_ready_i = 1'b0;
   endtask

   initial begin
      tick();
      chk_en = 1'b1;
      tick();
      rst_i = 1'b0;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_empty", 64'(empty_o), 64'd1);
      check("rst_valid", 64'(rd_valid_o), 64'd0);
      check("rst_cnts", 64'({total_cnt_o, drop_cnt_o}), 64'd0);

      // Single read on ch0
      trace_en_i = 1'b1;
      ch_valid_i = 2'b01;
      ch_addr_i[31:0] = 32'h40;
      tick();
      ch_valid_i = '0;
      check("lat_valid", 64'(rd_valid_o), 64'd1);
      check("lat_data", 64'(rd_data_o), 64'h40);
      check("lat_count", 64'(count_o), 64'd1);
      check("lat_total", 64'(total_cnt_o), 64'd1);
      rd_ready_i = 1'b1;
      tick();
      rd_ready_i = 1'b0;
      check("pop_empty", 64'(empty_o), 64'd1);

      // Disabled tracing captures nothing
      trace_en_i = 1'b0;
      ch_valid_i = 2'b11;
      tick();
      ch_valid_i = '0;
      trace_en_i = 1'b1;
      check("dis_total", 64'(total_cnt_o), 64'd1);
      check("dis_empty", 64'(empty_o), 64'd1);

      // Two channels at once: ch0 wins
      do_clear();
      ch_valid_i = 2'b11;
      ch_write_i = 2'b10;
      ch_addr_i  = {32'h20, 32'h10};
      tick();
      ch_valid_i = '0;
      ch_write_i = '0;
      check("arb_data", 64'(rd_data_o), 64'h10);
      check("arb_count", 64'(count_o), 64'd1);
      check("arb_drop", 64'(drop_cnt_o), 64'd1);
      check("arb_total", 64'(total_cnt_o), 64'd2);

      // Full, drop newest
      do_clear();
      overwrite_i = 1'b0;
      fill(18, 1, 0);
      check("drp_full", 64'(full_o), 64'd1);
      check("drp_drop", 64'(drop_cnt_o), 64'd2);
      drain_check(16, 1, 0, "drp_data");
      check("drp_empty", 64'(empty_o), 64'd1);

      // Full, overwrite oldest
      do_clear();
      overwrite_i = 1'b1;
      fill(18, 1, 0);
      check("ovw_count", 64'(count_o), 64'd16);
      check("ovw_drop", 64'(drop_cnt_o), 64'd2);
      drain_check(16, 1, 2, "ovw_data");
      check("ovw_empty", 64'(empty_o), 64'd1);
      fill(1, 0, 32'hAB);
      check("ovw_wrap", 64'(rd_data_o), 64'hAB);

      // Full with simultaneous push and pop
      do_clear();
      overwrite_i = 1'b0;
      fill(16, 0, 32'h100);
      check("fpp_head", 64'(rd_data_o), 64'h100);
      rd_ready_i = 1'b1;
      ch_valid_i = 2'b01;
      ch_addr_i[31:0] = 32'h200;
      tick();
      rd_ready_i = 1'b0;
      ch_valid_i = '0;
      check("fpp_count", 64'(count_o), 64'd16);
      check("fpp_drop", 64'(drop_cnt_o), 64'd0);
      check("fpp_next", 64'(rd_data_o), 64'h101);

      // Reset beats clear and same-cycle access
      rst_i = 1'b1;
      clear_i = 1'b1;
      ch_valid_i = 2'b01;
      tick();
      rst_i = 1'b0;
      clear_i = 1'b0;
      ch_valid_i = '0;
      check("mrst_empty", 64'(empty_o), 64'd1);
      check("mrst_total", 64'(total_cnt_o), 64'd0);

      // Drop counter saturation, then clear
      fill(16, 1, 0);
      ch_valid_i = 2'b11;
      for (int i = 0; i < 32767; i++) tick();
      check("sat_pre", 64'(drop_cnt_o), 64'hFFFE);
      tick();
      check("sat_hit", 64'(drop_cnt_o), 64'hFFFF);
      tick();
      check("sat_hold", 64'(drop_cnt_o), 64'hFFFF);
      check("sat_total", 64'(total_cnt_o), 64'hFFFF);
      ch_valid_i = '0;
      do_clear();
      check("clr_cnts", 64'({total_cnt_o, drop_cnt_o}), 64'd0);
      check("clr_empty", 64'(empty_o), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/access_trace_buffer.md
ACCESS_TRACE_BUFFER -- requirements
Module: access_trace_buffer

Interface
REQ-001 Parameter ADDR_W, default 32, traced address width.
REQ-002 Parameter CHANNELS, default 2, number of traced memory ports (>=1).
REQ-003 Parameter DEPTH, default 16, trace entries; power of two, >=2.
REQ-004 Parameter CNT_W, default 16, width of the event counters.
REQ-005 Derived: CH_W = max(1, clog2(CHANNELS)); PTR_W = clog2(DEPTH); ENTRY_W = CH_W+1+ADDR_W.
REQ-006 The block SHALL use one clock; reset is synchronous and active-high. Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous flush of buffer and counters
trace_en_i  in  1  1 = capture accesses
overwrite_i  in  1  1 = overwrite oldest when full, 0 = drop newest
ch_valid_i  in  CHANNELS  per-channel access strobe (read or write)
ch_write_i  in  CHANNELS  per-channel 1 = write, 0 = read
ch_addr_i  in  CHANNELS*ADDR_W  channel k address at bits [k*ADDR_W +: ADDR_W]
rd_valid_o  out  1  head entry available
rd_ready_i  in  1  consumer accepts head entry
rd_data_o  out  ENTRY_W  {ch_id, write, addr} of head entry
count_o  out  PTR_W+1  entries held
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
total_cnt_o  out  CNT_W  accesses offered while enabled
drop_cnt_o  out  CNT_W  accesses lost

Function
REQ-007 Offered access: ch_valid_i[k]=1 while trace_en_i=1; with trace_en_i=0 nothing is captured or counted.
REQ-008 At most one entry SHALL be written per cycle; the lowest-index offering channel wins, every other offering channel that cycle increments drop_cnt_o by one each.
REQ-009 total_cnt_o SHALL add the number of offered accesses each cycle; both counters saturate at 2^CNT_W-1, never wrap.
REQ-010 Buffer is a DEPTH-entry circular array, head/tail pointers wrap from DEPTH-1 to 0.
REQ-011 Pop occurs when rd_valid_o && rd_ready_i; push occurs when the winning access exists.
REQ-012 rd_valid_o = !empty_o; rd_data_o = entry at head, combinational from storage; undefined content ignored when rd_valid_o=0.
REQ-013 Latency: access offered in cycle N appears on rd_data_o/rd_valid_o in cycle N+1 when buffer was empty.
REQ-014 Not full: push writes tail, tail+1, count+1 (net 0 with simultaneous pop).
REQ-015 Full with simultaneous pop: push and pop both succeed, count unchanged, no drop.
REQ-016 Full without pop, overwrite_i=0: winning access discarded, drop_cnt_o+1, buffer unchanged.
REQ-017 Full without pop, overwrite_i=1: winning access written at tail, head and tail both advance, count stays DEPTH, drop_cnt_o+1 (oldest lost).
REQ-018 Pop when empty SHALL be impossible (rd_valid_o=0); rd_ready_i ignored.
REQ-019 Entry ch_id = winning channel index, zero-extended to CH_W.
REQ-020 clear_i=1: pointers, count, both counters zeroed that edge; any same-cycle access is neither stored nor counted; clear_i has priority over push/pop.

Reset
REQ-021 rst_i=1 at a rising edge: head=tail=0, count_o=0, empty_o=1, full_o=0, rd_valid_o=0, total_cnt_o=0, drop_cnt_o=0; storage contents not reset.
REQ-022 Reset mid-operation discards all entries and same-cycle accesses; rst_i has priority over clear_i.

Verification
REQ-023 Reset, trace_en_i=1, ch0 read 0x0000_0040 one cycle -> next cycle rd_valid_o=1, rd_data_o={0,0,0x40}, count_o=1, total_cnt_o=1.
REQ-024 Both channels valid same cycle (ch0 0x10, ch1 write 0x20) -> only {0,0,0x10} stored, drop_cnt_o=1, total_cnt_o=2.
REQ-025 DEPTH=16, overwrite_i=0, rd_ready_i=0, 18 ch1 accesses 0x0..0x11 -> full_o=1, drop_cnt_o=2, pops return 0x0..0xF in order, then empty_o=1.
REQ-026 Same as REQ-025 with overwrite_i=1 -> drop_cnt_o=2, pops return 0x2..0x11, pointers wrapped correctly.
REQ-027 Full buffer, rd_ready_i=1 and new access same cycle -> count_o stays 16, drop_cnt_o unchanged, popped entry is oldest.
REQ-028 Force drop_cnt_o to 0xFFFF (CNT_W=16) via repeated drops -> further drops hold 0xFFFF; then clear_i -> counters 0, empty_o=1.
